icache: RTL
===========

# icache

Direct-mapped, read-only instruction cache between the fetch stage and the word-wide backing RAM. Hits are served combinationally in the request cycle. On a miss, the block runs a fill state machine that fetches the whole line one 32-bit word at a time over the RAM's level req / pulse resp handshake, then serves the access from the cache.

## Interface
- NUM_LINES, 4, number of lines; power of two, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  fetch request, level.
- cpu_addr  in  32  fetch byte address; bits [1:0] are ignored.
- cpu_ready  out  1  hit this cycle; cpu_data is valid.
- cpu_data  out  32  instruction word; 0 when cpu_ready is low.
- mem_req  out  1  RAM request; held high for the whole fill.
- mem_addr  out  32  word-aligned RAM address; 0 when mem_req is low.
- mem_resp  in  1  one-cycle pulse; mem_data is valid in that cycle.
- mem_data  in  32  RAM read data.

## Operation
- Address split, with OFF = log2(LINE_WORDS) and IDX = log2(NUM_LINES):
  - bits [1:0]: byte offset, ignored.
  - bits [OFF+1:2]: word.
  - bits [OFF+IDX+1:OFF+2]: index.
  - remaining upper bits: tag.
- Storage per line: valid bit, tag, LINE_WORDS data words.
- State machine states: IDLE and FILL.
- IDLE:
  - hit = cpu_req & valid[idx] & (tag match).
  - On a hit: cpu_ready=1 and cpu_data=word, both combinational.
  - On cpu_req with a miss: latch the line base address (cpu_addr with word and byte bits cleared), clear word_cnt, go to FILL.
  - mem_resp is ignored in IDLE.
- FILL:
  - mem_req=1; mem_addr = base + 4*word_cnt.
  - cpu_ready=0.
  - On mem_resp: write mem_data into line[idx].word[word_cnt].
    - If word_cnt is not the last word: increment word_cnt.
    - If word_cnt == LINE_WORDS-1: set valid and tag, go to IDLE.
- mem_req stays high across word boundaries. Back-to-back words need no idle cycle; the RAM restarts its latency after each resp.
- mem_addr must remain stable while mem_req is high, because the RAM's read data is combinational on the address.
- The line's valid bit stays low for the entire fill. Words already written are not visible until the line completes.
- No hit-under-miss and no request queueing.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, word_cnt=0, all valid bits=0, base=0.
  - Outputs: cpu_ready=0, cpu_data=0, mem_req=0, mem_addr=0.
  - Data and tag arrays are not reset.
- Hit latency: 0 cycles (combinational).
- Miss latency: 1 (IDLE→FILL edge) + LINE_WORDS×(RAM word latency) + 1 (FILL→IDLE edge, then the hit is served in IDLE).
- The first mem_req is asserted in the cycle after the miss is detected.
- Boundary conditions:
  - cpu_addr changes or cpu_req drops during FILL: the fill of the latched line still completes. The new address is looked up in IDLE afterwards.
  - Miss to a valid line with a different tag: the line is evicted. Valid is cleared on FILL entry and refilled.
  - Reset asserted mid-fill:
    - mem_req drops asynchronously.
    - The partially filled line stays invalid.
    - A mem_resp arriving after reset is ignored.
  - word_cnt wraps to 0 only via the FILL→IDLE transition; it never overflows.

## Structure
- Belongs in brisc_pkg:
  - typedef enum logic {IDLE, FILL} icache_state_e.
  - Default NUM_LINES / LINE_WORDS constants.
  - Address-field width localparams.
- One sub-module, icache_array:
  - Holds the valid/tag/data storage.
  - One combinational read port (index, word).
  - One synchronous word-write port, with set-valid and clear-valid controls.
  - Asynchronous valid clear on rst.
- The FSM, counter and address datapath stay in icache.

## Test plan
- Cold miss: reset, then cpu_req=1, addr 0x0000_0010, RAM latency 3 with RAM[i]=i.
  - Expect mem_addr 0x10, 0x14, 0x18, 0x1C in order with mem_req continuously high.
  - Then cpu_ready=1, cpu_data=0x4.
- Hit after fill: addr 0x0000_0018 on the next cycle → cpu_ready=1 in the same cycle, cpu_data=0x6, mem_req=0.
- Conflict eviction: after the line at 0x10 is filled, request 0x0000_0050 (same index, different tag).
  - Expect a 4-word fill from 0x50.
  - Then 0x10 misses again.
- Address change mid-fill: switch cpu_addr from 0x20 to 0x44 after the 2nd mem_resp.
  - Expect the fill to finish at 0x2C.
  - Then a fresh miss fill starting at 0x40.
- Reset mid-fill: assert rst while word_cnt=2.
  - Expect mem_req=0 immediately.
  - Then a re-request of the same address misses and fills from word 0.
- Byte offset ignored: addr 0x0000_0013 after the line at 0x10 is filled → hit with cpu_data=RAM[0x10>>2].

Source files
------------

// File: rtl/brisc_pkg.sv
// Shared types and default geometry for the brisc instruction cache.
package brisc_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BYTE_OFF_W = 2;

    localparam int ICACHE_NUM_LINES  = 4;
    localparam int ICACHE_LINE_WORDS = 4;
    localparam int ICACHE_OFF_W      = $clog2(ICACHE_LINE_WORDS);
    localparam int ICACHE_IDX_W      = $clog2(ICACHE_NUM_LINES);
    localparam int ICACHE_TAG_W      = ADDR_W - BYTE_OFF_W - ICACHE_OFF_W - ICACHE_IDX_W;

    typedef enum logic {IDLE, FILL} icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped icache.
// Combinational read port; synchronous word write with valid set/clear.
module icache_array
    import brisc_pkg::*;
#(
    parameter int NUM_LINES  = ICACHE_NUM_LINES,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int TAG_W      = ICACHE_TAG_W,
    localparam int IDX_W     = $clog2(NUM_LINES),
    localparam int OFF_W     = $clog2(LINE_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [IDX_W-1:0]  i_rd_idx,
    input  logic [OFF_W-1:0]  i_rd_word,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [OFF_W-1:0]  i_wr_word,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic              i_set_valid,
    input  logic              i_clr_valid
);

    logic [DATA_W-1:0]    r_data [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;

    // Data and tags are deliberately left unreset; valid alone gates hits.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_data[i_wr_idx][i_wr_word] <= i_wr_data;
        end
        if (i_set_valid) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (i_clr_valid) begin
            r_valid[i_wr_idx] <= 1'b0;
        end else if (i_set_valid) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx][i_rd_word];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hits, and a
// line fill one word at a time over a level-req / pulse-resp RAM port.
module icache
    import brisc_pkg::*;
#(
    parameter int NUM_LINES  = ICACHE_NUM_LINES,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    output logic              o_cpu_ready,
    output logic [DATA_W-1:0] o_cpu_data,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_resp,
    input  logic [DATA_W-1:0] i_mem_data
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int LO_IDX = BYTE_OFF_W + OFF_W;
    localparam int LO_TAG = LO_IDX + IDX_W;
    localparam int TAG_W  = ADDR_W - LO_TAG;
    localparam int LINE_W = ADDR_W - LO_IDX;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    icache_state_e     r_state, w_state_nxt;
    logic [OFF_W-1:0]  r_cnt, w_cnt_nxt;
    logic [LINE_W-1:0] r_line, w_line_nxt;

    logic [OFF_W-1:0]  w_cpu_word;
    logic [IDX_W-1:0]  w_cpu_idx;
    logic [TAG_W-1:0]  w_cpu_tag;
    logic              w_unused_byte;
    logic              w_rd_valid;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [DATA_W-1:0] w_rd_data;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_wr_en, w_set_valid, w_clr_valid, w_hit;

    assign w_cpu_word    = i_cpu_addr[LO_IDX-1:BYTE_OFF_W];
    assign w_cpu_idx     = i_cpu_addr[LO_TAG-1:LO_IDX];
    assign w_cpu_tag     = i_cpu_addr[ADDR_W-1:LO_TAG];
    assign w_unused_byte = ^i_cpu_addr[BYTE_OFF_W-1:0];

    icache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_array (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rd_idx    (w_cpu_idx),
        .i_rd_word   (w_cpu_word),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_data   (w_rd_data),
        .i_wr_idx    (w_wr_idx),
        .i_wr_word   (r_cnt),
        .i_wr_en     (w_wr_en),
        .i_wr_data   (i_mem_data),
        .i_wr_tag    (r_line[LINE_W-1:IDX_W]),
        .i_set_valid (w_set_valid),
        .i_clr_valid (w_clr_valid)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_line  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_line  <= w_line_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_line_nxt  = r_line;
        w_wr_idx    = r_line[IDX_W-1:0];
        w_wr_en     = 1'b0;
        w_set_valid = 1'b0;
        w_clr_valid = 1'b0;
        w_hit       = 1'b0;
        o_cpu_ready = 1'b0;
        o_cpu_data  = '0;
        o_mem_req   = 1'b0;
        o_mem_addr  = '0;
        case (r_state)
            IDLE: begin
                w_hit = i_cpu_req && w_rd_valid && (w_rd_tag == w_cpu_tag);
                if (w_hit) begin
                    o_cpu_ready = 1'b1;
                    o_cpu_data  = w_rd_data;
                end else if (i_cpu_req) begin
                    // Evict up front so the line never looks valid mid-fill.
                    w_wr_idx    = w_cpu_idx;
                    w_clr_valid = 1'b1;
                    w_line_nxt  = i_cpu_addr[ADDR_W-1:LO_IDX];
                    w_cnt_nxt   = '0;
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                o_mem_req  = 1'b1;
                o_mem_addr = {r_line, r_cnt, {BYTE_OFF_W{1'b0}}};
                if (i_mem_resp) begin
                    w_wr_en = 1'b1;
                    if (r_cnt == LAST_WORD) begin
                        w_set_valid = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + OFF_W'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
